// File: rtl/reflet_timer_ext.sv
// Reflet timer, extended: prescaler plus an auto-reload counter of cnt_bytes bytes,
// with one-shot/periodic mode, external edge counting, sticky W1C flag and live count.
module reflet_timer_ext #(
  parameter int                        base_addr_size = 16,
  parameter logic [base_addr_size-1:0] base_addr      = 16'hFF10,
  parameter int                        cnt_bytes      = 2
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      enable,
  input  logic [base_addr_size-1:0] addr,
  input  logic                      write_en,
  input  logic [7:0]                data_in,
  output logic [7:0]                data_out,
  input  logic                      timer_input,
  output logic                      interrupt
);
  localparam int W    = 8 * cnt_bytes;
  localparam int NREG = 3 + 2 * cnt_bytes;
  localparam logic [base_addr_size:0]   LAST     = {1'b0, base_addr} + (base_addr_size+1)'(NREG);
  localparam logic [base_addr_size-1:0] OFF_CTRL = base_addr_size'(0);
  localparam logic [base_addr_size-1:0] OFF_PRE  = base_addr_size'(1);
  localparam logic [base_addr_size-1:0] OFF_STAT = base_addr_size'(2);

  logic [3:0]   r_ctrl;
  logic [7:0]   r_pre;
  logic         r_flag;
  logic [W-1:0] r_arr;
  logic [W-1:0] r_cnt;
  logic [7:0]   r_psc;
  logic         r_prev;

  logic [base_addr_size-1:0] w_off;
  logic                      w_sel;
  logic                      w_wr;
  logic                      w_running;
  logic                      w_event;
  logic                      w_tick;
  logic                      w_expire;
  logic                      w_restart;
  logic [cnt_bytes-1:0]      w_arr_we;

  assign w_sel = enable && (addr >= base_addr) && ({1'b0, addr} < LAST);
  assign w_off = addr - base_addr;
  assign w_wr  = w_sel && write_en;

  generate
    for (genvar gi = 0; gi < cnt_bytes; gi++) begin : g_arr_we
      assign w_arr_we[gi] = w_wr && (w_off == base_addr_size'(3 + gi));
    end
  endgenerate

  assign w_running = r_ctrl[0] && (r_arr != '0);
  assign w_event   = r_ctrl[2] ? (timer_input && !r_prev) : 1'b1;
  assign w_restart = (w_wr && (w_off == OFF_PRE)) || (|w_arr_we);
  assign w_tick    = w_running && w_event && (r_psc == r_pre);
  // A reload write on the same edge cancels the expiry along with the count.
  assign w_expire  = w_tick && (r_cnt == r_arr - W'(1)) && !w_restart;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_ctrl <= '0;
      r_pre  <= '0;
      r_flag <= 1'b0;
      r_arr  <= '0;
      r_cnt  <= '0;
      r_psc  <= '0;
      r_prev <= 1'b0;
    end else begin
      r_prev <= timer_input;

      if (w_wr && (w_off == OFF_CTRL))
        r_ctrl <= data_in[3:0];
      else if (w_expire && r_ctrl[1])
        r_ctrl[0] <= 1'b0;

      if (w_wr && (w_off == OFF_PRE))
        r_pre <= data_in;

      for (int i = 0; i < cnt_bytes; i++)
        if (w_arr_we[i])
          r_arr[8*i +: 8] <= data_in;

      if (w_expire)
        r_flag <= 1'b1;
      else if (w_wr && (w_off == OFF_STAT) && data_in[0])
        r_flag <= 1'b0;

      if (!w_running || w_restart) begin
        r_psc <= '0;
        r_cnt <= '0;
      end else if (w_event) begin
        if (w_tick) begin
          r_psc <= '0;
          r_cnt <= w_expire ? '0 : r_cnt + W'(1);
        end else begin
          r_psc <= r_psc + 8'd1;
        end
      end
    end
  end

  always_comb begin
    data_out = 8'h00;
    if (w_sel && !reset) begin
      if (w_off == OFF_CTRL) data_out = {4'h0, r_ctrl};
      if (w_off == OFF_PRE)  data_out = r_pre;
      if (w_off == OFF_STAT) data_out = {6'h00, w_running, r_flag};
      for (int i = 0; i < cnt_bytes; i++) begin
        if (w_off == base_addr_size'(3 + i))             data_out = r_arr[8*i +: 8];
        if (w_off == base_addr_size'(3 + cnt_bytes + i)) data_out = r_cnt[8*i +: 8];
      end
    end
  end

  assign interrupt = r_flag && r_ctrl[3];

endmodule

// File: tb/tb_reflet_timer_ext.sv
// Directed and randomised checks of reflet_timer_ext against an event-count
// reference model (period position kept as a plain event tally).
module tb_reflet_timer_ext;
  localparam int          AW   = 16;
  localparam logic [15:0] BASE = 16'hFF10;
  localparam int          CB   = 2;
  localparam int          NREG = 3 + 2*CB;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        enable = 1'b0;
  logic        write_en = 1'b0;
  logic        timer_input = 1'b0;
  logic [15:0] addr = '0;
  logic [7:0]  data_in = '0;
  logic [7:0]  data_out;
  logic        interrupt;

  int n_checks = 0;
  int n_pass   = 0;

  reflet_timer_ext #(.base_addr_size(AW), .base_addr(BASE), .cnt_bytes(CB)) dut (
    .clk(clk), .reset(reset), .enable(enable), .addr(addr), .write_en(write_en),
    .data_in(data_in), .data_out(data_out), .timer_input(timer_input), .interrupt(interrupt)
  );

  always #5 clk = ~clk;

  // Reference model: m_ev counts events since the start of the current period.
  logic [3:0]      m_ctrl;
  logic [7:0]      m_pre;
  longint unsigned m_arr;
  longint unsigned m_ev;
  logic            m_flag;
  logic            m_prev;

  function automatic bit m_running();
    return m_ctrl[0] && (m_arr != 0);
  endfunction

  function automatic logic [7:0] m_read(input logic en, input logic [15:0] a);
    int off = int'(a) - int'(BASE);
    longint unsigned cnt = m_ev / (longint'(m_pre) + 1);
    if (!en || off < 0 || off >= NREG || reset) return 8'h00;
    if (off == 0) return {4'h0, m_ctrl};
    if (off == 1) return m_pre;
    if (off == 2) return {6'h00, m_running(), m_flag};
    if (off < 3 + CB) return 8'((m_arr >> (8*(off-3))) & 64'hFF);
    return 8'((cnt >> (8*(off-3-CB))) & 64'hFF);
  endfunction

  task automatic m_reset();
    m_ctrl = '0; m_pre = '0; m_arr = 0; m_ev = 0; m_flag = 1'b0; m_prev = 1'b0;
  endtask

  task automatic m_step();
    int off = int'(addr) - int'(BASE);
    bit sel = enable && off >= 0 && off < NREG;
    bit wr = sel && write_en;
    bit run = m_running();
    bit ev = m_ctrl[2] ? (timer_input && !m_prev) : 1'b1;
    bit restart = wr && (off == 1 || (off >= 3 && off < 3 + CB));
    longint unsigned period = (longint'(m_pre) + 1) * m_arr;
    bit expire = run && !restart && ev && (m_ev + 1 == period);
    if (!run || restart) m_ev = 0;
    else if (ev) m_ev = expire ? 0 : m_ev + 1;
    if (expire) m_flag = 1'b1;
    else if (wr && off == 2 && data_in[0]) m_flag = 1'b0;
    if (wr && off == 0) m_ctrl = data_in[3:0];
    else if (expire && m_ctrl[1]) m_ctrl[0] = 1'b0;
    if (wr && off == 1) m_pre = data_in;
    if (wr && off >= 3 && off < 3 + CB) begin
      longint unsigned mask = 64'hFF << (8*(off-3));
      longint unsigned byt = 64'(data_in) << (8*(off-3));
      m_arr = (m_arr & ~mask) | byt;
    end
    m_prev = timer_input;
  endtask

  task automatic tick();
    if (reset) m_reset(); else m_step();
    @(posedge clk);
    #1;
  endtask

  task automatic bus_cycle(input logic en, input logic [15:0] a, input logic we,
                           input logic [7:0] d, output logic [7:0] q);
    enable = en; addr = a; write_en = we; data_in = d;
    #1 q = data_out;
    tick();
    enable = 1'b0; write_en = 1'b0;
  endtask

  task automatic wr(input int off, input logic [7:0] d);
    logic [7:0] q;
    bus_cycle(1'b1, BASE + 16'(off), 1'b1, d, q);
  endtask

  task automatic rd(input int off, output logic [7:0] q);
    bus_cycle(1'b1, BASE + 16'(off), 1'b0, 8'h00, q);
  endtask

  task automatic test_reset();
    logic [7:0] q;
    reset = 1'b1; m_reset();
    repeat (3) tick();
    reset = 1'b0;
    wr(1, 8'd2); wr(3, 8'd3); wr(4, 8'd0); wr(0, 8'h09);
    repeat (13) tick();
    n_checks++;
    if (interrupt !== 1'b1) $display("FAIL reset_pre_irq: got %b want 1", interrupt);
    else n_pass++;
    #2 reset = 1'b1; m_reset();
    #1;
    n_checks++;
    if (interrupt !== 1'b0) $display("FAIL reset_irq: got %b want 0", interrupt);
    else n_pass++;
    for (int off = 0; off < NREG; off++) begin
      rd(off, q);
      n_checks++;
      if (q !== 8'h00) $display("FAIL reset_read_in_reset off=%0d: got %h want 00", off, q);
      else n_pass++;
    end
    reset = 1'b0;
    for (int off = 0; off < NREG; off++) begin
      rd(off, q);
      n_checks++;
      if (q !== 8'h00) $display("FAIL reset_read_after off=%0d: got %h want 00", off, q);
      else n_pass++;
    end
  endtask

  task automatic test_periodic();
    int n = 0;
    wr(0, 8'h00); wr(2, 8'h01); wr(1, 8'd3); wr(3, 8'd5); wr(4, 8'd0); wr(0, 8'h09);
    while (interrupt !== 1'b1 && n < 100) begin
      tick(); n++;
      n_checks++;
      if (interrupt !== (m_flag & m_ctrl[3])) $display("FAIL periodic_irq cyc=%0d: got %b want %b", n, interrupt, m_flag & m_ctrl[3]);
      else n_pass++;
    end
    n_checks++;
    if (n !== 20) $display("FAIL periodic_first_expiry: got %0d cycles want 20", n);
    else n_pass++;
    wr(2, 8'h01);
    n_checks++;
    if (interrupt !== 1'b0) $display("FAIL periodic_clear: got %b want 0", interrupt);
    else n_pass++;
    n = 1;
    while (interrupt !== 1'b1 && n < 100) begin
      tick(); n++;
    end
    n_checks++;
    if (n !== 20) $display("FAIL periodic_second_expiry: got %0d cycles want 20", n);
    else n_pass++;
  endtask

  task automatic test_oneshot();
    logic [7:0] q;
    wr(0, 8'h00); wr(2, 8'h01); wr(1, 8'd0); wr(3, 8'd3); wr(4, 8'd0); wr(0, 8'h03);
    tick(); tick();
    rd(2, q);
    n_checks++;
    if (q !== 8'h02) $display("FAIL oneshot_early_status: got %h want 02", q);
    else n_pass++;
    rd(2, q);
    n_checks++;
    if (q !== 8'h01) $display("FAIL oneshot_status: got %h want 01", q);
    else n_pass++;
    rd(0, q);
    n_checks++;
    if (q !== 8'h02) $display("FAIL oneshot_ctrl: got %h want 02", q);
    else n_pass++;
    rd(5, q);
    n_checks++;
    if (q !== 8'h00) $display("FAIL oneshot_cnt: got %h want 00", q);
    else n_pass++;
    wr(2, 8'h01);
    repeat (50) tick();
    rd(2, q);
    n_checks++;
    if (q !== 8'h00) $display("FAIL oneshot_no_rerun: got %h want 00", q);
    else n_pass++;
  endtask

  task automatic test_ext();
    logic [7:0] q;
    logic [7:0] e;
    wr(0, 8'h00); wr(2, 8'h01); wr(1, 8'd1); wr(3, 8'd2); wr(4, 8'd0); wr(0, 8'h05);
    for (int p = 1; p <= 10; p++) begin
      for (int c = 0; c < 4; c++) begin
        int off = (c < 2) ? 2 : 5;
        timer_input = (c == 0);
        e = m_read(1'b1, BASE + 16'(off));
        rd(off, q);
        n_checks++;
        if (q !== e) $display("FAIL ext_model p=%0d c=%0d: got %h want %h", p, c, q, e);
        else n_pass++;
        if (c == 1 && (p == 3 || p == 4)) begin
          n_checks++;
          if (q[0] !== (p == 4)) $display("FAIL ext_flag p=%0d: got %b want %b", p, q[0], p == 4);
          else n_pass++;
        end
        if (c == 2 && p == 6) begin
          n_checks++;
          if (q !== 8'h01) $display("FAIL ext_cnt6: got %h want 01", q);
          else n_pass++;
        end
      end
    end
    timer_input = 1'b1;
    repeat (3) tick();
    for (int i = 0; i < 5; i++) begin
      rd(5, q);
      n_checks++;
      if (q !== 8'h01) $display("FAIL ext_held_high i=%0d: got %h want 01", i, q);
      else n_pass++;
    end
    timer_input = 1'b0;
    wr(0, 8'h00);
  endtask

  task automatic test_collision();
    logic [7:0] q;
    wr(0, 8'h00); wr(2, 8'h01); wr(1, 8'd0); wr(3, 8'd4); wr(4, 8'd0); wr(0, 8'h01);
    repeat (3) tick();
    wr(2, 8'h01);
    rd(2, q);
    n_checks++;
    if (q[0] !== 1'b1) $display("FAIL collision_flag: got %b want 1", q[0]);
    else n_pass++;
    wr(0, 8'h00);
    bus_cycle(1'b0, BASE + 16'd1, 1'b1, 8'hAA, q);
    bus_cycle(1'b0, BASE, 1'b1, 8'h0F, q);
    bus_cycle(1'b1, BASE - 16'd1, 1'b1, 8'h55, q);
    n_checks++;
    if (q !== 8'h00) $display("FAIL oor_low_read: got %h want 00", q);
    else n_pass++;
    bus_cycle(1'b1, BASE + 16'(NREG), 1'b1, 8'h66, q);
    n_checks++;
    if (q !== 8'h00) $display("FAIL oor_high_read: got %h want 00", q);
    else n_pass++;
    bus_cycle(1'b0, BASE + 16'd3, 1'b0, 8'h00, q);
    n_checks++;
    if (q !== 8'h00) $display("FAIL disabled_read: got %h want 00", q);
    else n_pass++;
    rd(0, q);
    n_checks++;
    if (q !== 8'h00) $display("FAIL guard_ctrl: got %h want 00", q);
    else n_pass++;
    rd(1, q);
    n_checks++;
    if (q !== 8'h00) $display("FAIL guard_pre: got %h want 00", q);
    else n_pass++;
    rd(3, q);
    n_checks++;
    if (q !== 8'h04) $display("FAIL guard_arr0: got %h want 04", q);
    else n_pass++;
    rd(4, q);
    n_checks++;
    if (q !== 8'h00) $display("FAIL guard_arr1: got %h want 00", q);
    else n_pass++;
  endtask

  task automatic test_boundary();
    logic [7:0] q;
    int n = 0;
    wr(0, 8'h00); wr(2, 8'h01); wr(3, 8'h00); wr(4, 8'h00); wr(0, 8'h01);
    repeat (10) tick();
    rd(2, q);
    n_checks++;
    if (q !== 8'h00) $display("FAIL arr0_status: got %h want 00", q);
    else n_pass++;
    rd(5, q);
    n_checks++;
    if (q !== 8'h00) $display("FAIL arr0_cnt: got %h want 00", q);
    else n_pass++;
    wr(0, 8'h00); wr(1, 8'h00); wr(3, 8'hFF); wr(4, 8'hFF); wr(2, 8'h01); wr(0, 8'h09);
    while (interrupt !== 1'b1 && n < 70000) begin
      tick(); n++;
    end
    n_checks++;
    if (n !== 65535) $display("FAIL max_arr_period: got %0d cycles want 65535", n);
    else n_pass++;
    repeat (5) tick();
    rd(5, q);
    n_checks++;
    if (q !== 8'h05) $display("FAIL max_arr_cnt: got %h want 05", q);
    else n_pass++;
    wr(3, 8'hFF);
    rd(5, q);
    n_checks++;
    if (q !== 8'h00) $display("FAIL arr_write_restart_lo: got %h want 00", q);
    else n_pass++;
    rd(6, q);
    n_checks++;
    if (q !== 8'h00) $display("FAIL arr_write_restart_hi: got %h want 00", q);
    else n_pass++;
    wr(0, 8'h00);
  endtask

  task automatic test_random();
    for (int c = 0; c < 3000; c++) begin
      int          kind = $urandom_range(0, 9);
      logic [15:0] a = BASE + 16'($urandom_range(0, NREG-1));
      logic        en = ($urandom_range(0, 7) != 0);
      logic        we = ($urandom_range(0, 3) == 0);
      logic [7:0]  d = 8'($urandom);
      logic [7:0]  exp_q;
      logic        exp_irq;
      if (kind == 0) a = BASE - 16'd1;
      else if (kind == 1) a = BASE + 16'(NREG);
      if (a == BASE + 16'd1) d = d & 8'h03;
      if (a == BASE + 16'd3) d = d & 8'h07;
      if (a == BASE + 16'd4) d = ($urandom_range(0, 15) == 0) ? 8'h01 : 8'h00;
      timer_input = 1'($urandom_range(0, 1));
      enable = en; addr = a; write_en = we; data_in = d;
      #1;
      exp_q = m_read(en, a);
      exp_irq = m_flag & m_ctrl[3];
      n_checks++;
      if (data_out !== exp_q) $display("FAIL rand_read c=%0d addr=%h: got %h want %h", c, a, data_out, exp_q);
      else n_pass++;
      n_checks++;
      if (interrupt !== exp_irq) $display("FAIL rand_irq c=%0d: got %b want %b", c, interrupt, exp_irq);
      else n_pass++;
      tick();
    end
    enable = 1'b0; write_en = 1'b0; timer_input = 1'b0;
  endtask

  initial begin
    test_reset();
    test_periodic();
    test_oneshot();
    test_ext();
    test_collision();
    test_boundary();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
